bp_network_deserializer: RTL and testbench
==========================================

BP_NETWORK_DESERIALIZER -- requirements
Module: bp_network_deserializer

Interface
REQ-001 Parameter num_dest, no default ("inv"): number of destinations; dest_id_width_p = BSG_SAFE_CLOG2(num_dest).
REQ-002 Parameter num_src, no default ("inv"): number of sources; src_id_width_p = BSG_SAFE_CLOG2(num_src).
REQ-003 Parameter source_data_width_p, no default ("inv"): width of the reassembled message.
REQ-004 Parameter packet_data_width_p, no default ("inv"): payload width per flit; num_packets_p = ceil(source_data_width_p / packet_data_width_p); flit width total_i_data_width = packet_data_width_p + dest_id_width_p + src_id_width_p.
REQ-005 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_i  input  1  reset, asynchronous and active-high.
REQ-007 valid_i  input  1  flit valid.
REQ-008 data_i  input  total_i_data_width  flit; [MSB -: dest+src] = {dest_id, src_id}, [packet_data_width_p-1:0] = payload.
REQ-009 ready_o  output  1  block can accept a flit this cycle.
REQ-010 valid_o  output  1  reassembled message available.
REQ-011 data_o  output  source_data_width_p  reassembled message.
REQ-012 dest_id_o  output  dest_id_width_p  header dest_id of the first flit of the message.
REQ-013 src_id_o  output  src_id_width_p  header src_id of the first flit of the message.
REQ-014 hdr_err_o  output  1  header mismatch flag, qualified by valid_o.
REQ-015 yumi_i  input  1  consumer takes the message; legal only while valid_o=1.

Function
REQ-016 A flit is accepted when valid_i & ready_o are both 1 on a rising clock edge.
REQ-017 FSM has two states: eRecv (collecting flits) and eFull (holding a complete message).
REQ-018 In eRecv: ready_o=1 and valid_o=0. In eFull: ready_o=0 and valid_o=1.
REQ-019 Counter cnt_r has width BSG_SAFE_CLOG2(num_packets_p) and counts accepted flits of the current message. It starts at 0.
REQ-020 Flit k (cnt_r=k) payload is written to buffer slice [k*packet_data_width_p +: packet_data_width_p]; flit 0 is least significant.
REQ-021 On acceptance with cnt_r < num_packets_p-1, cnt_r increments and the state stays eRecv.
REQ-022 On acceptance with cnt_r = num_packets_p-1, cnt_r returns to 0 and the state moves to eFull.
REQ-023 valid_o rises on the cycle after the final flit is accepted, so the latency from the last flit to valid_o is 1 cycle.
REQ-024 When num_packets_p=1, every accepted flit moves the state directly to eFull.
REQ-025 On acceptance with cnt_r=0, dest_id_o and src_id_o are captured from the flit header and hdr_err_r is cleared.
REQ-026 On acceptance with cnt_r>0, hdr_err_r is set if the flit's {dest_id, src_id} differs from the captured values; once set, it stays set until the next first flit.
REQ-027 data_o = buffer[source_data_width_p-1:0]; the buffer's upper padding bits (total width minus source_data_width_p) are discarded.
REQ-028 In eFull with yumi_i=1, the state moves to eRecv on the next edge; ready_o returns to 1 that next cycle, and there is no same-cycle pass-through.
REQ-029 In eFull with yumi_i=0, data_o, dest_id_o, src_id_o and hdr_err_o hold stable.
REQ-030 yumi_i asserted in eRecv is a protocol violation; the block ignores it (the bench asserts it never occurs).
REQ-031 valid_i asserted while ready_o=0 does not change state; the upstream must hold the flit.
REQ-032 Outputs depend only on registers, with no combinational path from inputs to outputs.
REQ-033 Throughput: one message per num_packets_p+1 cycles at full rate.

Reset
REQ-034 reset_i asserted asynchronously sets state=eRecv, cnt_r=0 and hdr_err_r=0, immediately and independent of clk_i.
REQ-035 During reset: valid_o=0, ready_o=1, hdr_err_o=0, dest_id_o=0, src_id_o=0 and data_o=0 (buffer cleared).
REQ-036 A reset arriving mid-message or in eFull discards the partial or held message; the first flit after reset is treated as flit 0.

Verification
Configuration for all scenarios: num_dest=4, num_src=4, source_data_width_p=20, packet_data_width_p=8, so num_packets_p=3 and the flit width is 12.
REQ-037 Flits 0x6AB, 0x6CD, 0x6EF back-to-back, yumi_i held 1 -> one cycle after the 3rd flit: valid_o=1, data_o=0xFCDAB, dest_id_o=1, src_id_o=2, hdr_err_o=0; ready_o=1 on the following cycle.
REQ-038 Same flits with yumi_i=0 for 5 cycles -> valid_o and data_o stable, ready_o=0, a 4th offered flit not accepted; then yumi_i=1 -> ready_o=1 on the next cycle.
REQ-039 Flits 0x611, 0x722, 0x633 -> hdr_err_o=1 with valid_o; the next clean message -> hdr_err_o=0.
REQ-040 Two flits accepted, then reset_i pulsed asynchronously (between edges) -> ready_o=1 and valid_o=0 immediately; the next 3 flits form a clean message.
REQ-041 Random valid_i gaps (50% duty) and random yumi_i delays over 1000 messages -> a scoreboard matches every data_o, dest_id_o and src_id_o, with no loss or duplication.
REQ-042 num_packets_p=1 configuration (packet_data_width_p=20), flit accepted -> valid_o=1 next cycle with data_o equal to the payload.

Source files
------------

// File: rtl/bp_network_deserializer.sv
// Reassembles num_packets_p header-tagged flits into one message and holds it
// until the consumer takes it with yumi_i; the headers of all flits are cross-checked.
module bp_network_deserializer #(
    parameter int num_dest            = 4,
    parameter int num_src             = 4,
    parameter int source_data_width_p = 20,
    parameter int packet_data_width_p = 8,
    localparam int dest_id_width_p    = (num_dest > 1) ? $clog2(num_dest) : 1,
    localparam int src_id_width_p     = (num_src > 1) ? $clog2(num_src) : 1,
    localparam int total_i_data_width = packet_data_width_p + dest_id_width_p + src_id_width_p
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           valid_i,
    input  logic [total_i_data_width-1:0]  data_i,
    output logic                           ready_o,
    output logic                           valid_o,
    output logic [source_data_width_p-1:0] data_o,
    output logic [dest_id_width_p-1:0]     dest_id_o,
    output logic [src_id_width_p-1:0]      src_id_o,
    output logic                           hdr_err_o,
    input  logic                           yumi_i
);

    localparam int num_packets_p = (source_data_width_p + packet_data_width_p - 1) / packet_data_width_p;
    localparam int cnt_width_lp  = (num_packets_p > 1) ? $clog2(num_packets_p) : 1;
    localparam int hdr_width_lp  = dest_id_width_p + src_id_width_p;

    typedef enum logic {eRecv, eFull} state_e;

    state_e                          state_r;
    state_e                          state_n;
    logic [cnt_width_lp-1:0]         cnt_r;
    logic [source_data_width_p-1:0]  buf_r;
    logic [hdr_width_lp-1:0]         hdr;
    logic [packet_data_width_p-1:0]  payload;
    logic                            accept;
    logic                            last;

    assign hdr     = data_i[total_i_data_width-1 -: hdr_width_lp];
    assign payload = data_i[packet_data_width_p-1:0];
    assign accept  = valid_i && (state_r == eRecv);
    assign last    = (cnt_r == cnt_width_lp'(num_packets_p - 1));
    assign data_o  = buf_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= eRecv;
            cnt_r     <= '0;
            hdr_err_o <= 1'b0;
            dest_id_o <= '0;
            src_id_o  <= '0;
        end else begin
            state_r <= state_n;
            if (accept) begin
                cnt_r <= last ? '0 : cnt_r + cnt_width_lp'(1);
                // The first flit defines the reference header for the whole message
                if (cnt_r == '0) begin
                    dest_id_o <= hdr[hdr_width_lp-1 -: dest_id_width_p];
                    src_id_o  <= hdr[src_id_width_p-1:0];
                    hdr_err_o <= 1'b0;
                end else if (hdr != {dest_id_o, src_id_o}) begin
                    hdr_err_o <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_n = state_r;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_r)
            eRecv: begin
                ready_o = 1'b1;
                if (valid_i && last) state_n = eFull;
            end
            eFull: begin
                valid_o = 1'b1;
                if (yumi_i) state_n = eRecv;
            end
            default: state_n = eRecv;
        endcase
    end

    // Only the bits of each slice that fall inside the message are stored;
    // padding of the top flit is dropped on the way in.
    for (genvar k = 0; k < num_packets_p; k++) begin : g_slice
        localparam int lo = k * packet_data_width_p;
        localparam int w  = (source_data_width_p - lo < packet_data_width_p)
                            ? (source_data_width_p - lo) : packet_data_width_p;

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                buf_r[lo +: w] <= '0;
            end else if (accept && (cnt_r == cnt_width_lp'(k))) begin
                buf_r[lo +: w] <= payload[w-1:0];
            end
        end
    end

endmodule

// File: tb/tb_bp_network_deserializer.sv
// Self-checking bench for bp_network_deserializer: directed scenarios plus a
// randomized run scored against a message-level reference queue.
module tb_bp_network_deserializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        valid = 1'b0;
    logic [11:0] data  = '0;
    logic        ready;
    logic        vo;
    logic [19:0] dout;
    logic [1:0]  dest;
    logic [1:0]  src;
    logic        herr;
    logic        yumi = 1'b0;

    logic        valid1 = 1'b0;
    logic [23:0] data1  = '0;
    logic        ready1;
    logic        vo1;
    logic [19:0] dout1;
    logic [1:0]  dest1;
    logic [1:0]  src1;
    logic        herr1;
    logic        yumi1 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int abort    = 0;

    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    bp_network_deserializer #(
        .num_dest(4), .num_src(4), .source_data_width_p(20), .packet_data_width_p(8)
    ) dut (
        .clk_i(clk), .reset_i(rst), .valid_i(valid), .data_i(data),
        .ready_o(ready), .valid_o(vo), .data_o(dout), .dest_id_o(dest),
        .src_id_o(src), .hdr_err_o(herr), .yumi_i(yumi)
    );

    bp_network_deserializer #(
        .num_dest(4), .num_src(4), .source_data_width_p(20), .packet_data_width_p(20)
    ) dut1 (
        .clk_i(clk), .reset_i(rst), .valid_i(valid1), .data_i(data1),
        .ready_o(ready1), .valid_o(vo1), .data_o(dout1), .dest_id_o(dest1),
        .src_id_o(src1), .hdr_err_o(herr1), .yumi_i(yumi1)
    );

    // yumi is only legal while a message is being presented
    always @(posedge clk) begin
        if (!rst && ((yumi && !vo) || (yumi1 && !vo1))) begin
            n_checks++;
            n_fail++;
            $display("FAIL yumi_protocol: yumi=%b valid_o=%b yumi1=%b valid_o1=%b", yumi, vo, yumi1, vo1);
        end
    end

    task automatic send_flit(input logic [11:0] f);
        int   n;
        logic acc;
        valid = 1'b1;
        data  = f;
        n     = 0;
        do begin
            acc = ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_flit_timeout: flit %h got ready=0 want accepted within 50 cycles", f);
            abort = 1;
        end
    endtask

    task automatic consume();
        yumi = 1'b1;
        @(posedge clk); #1;
        yumi = 1'b0;
        n_checks++;
        if ({ready, vo} !== 2'b10) begin
            n_fail++;
            $display("FAIL consume_release: got ready,valid=%b want 10", {ready, vo});
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({ready, vo, herr, dest, src, dout} !== {1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 20'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b v=%b err=%b d=%0d s=%0d data=%h want 1 0 0 0 0 00000",
                     ready, vo, herr, dest, src, dout);
        end
        n_checks++;
        if ({ready1, vo1, herr1, dest1, src1, dout1} !== {1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 20'd0}) begin
            n_fail++;
            $display("FAIL reset_state_single: got rdy=%b v=%b data=%h want 1 0 00000", ready1, vo1, dout1);
        end
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        send_flit(12'h6AB);
        send_flit(12'h6CD);
        send_flit(12'h6EF);
        valid = 1'b0;
        n_checks++;
        if ({vo, ready, dout, dest, src, herr} !== {1'b1, 1'b0, 20'hFCDAB, 2'd1, 2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_msg: got v=%b rdy=%b data=%h d=%0d s=%0d err=%b want 1 0 fcdab 1 2 0",
                     vo, ready, dout, dest, src, herr);
        end
        consume();
    endtask

    task automatic test_hold();
        send_flit(12'h6AB);
        send_flit(12'h6CD);
        send_flit(12'h6EF);
        // offer an extra flit while the message is held; it must not be taken
        valid = 1'b1;
        data  = 12'h5FF;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({vo, ready, dout, dest, src, herr} !== {1'b1, 1'b0, 20'hFCDAB, 2'd1, 2'd2, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: got v=%b rdy=%b data=%h d=%0d s=%0d want 1 0 fcdab 1 2",
                         i, vo, ready, dout, dest, src);
            end
            @(posedge clk); #1;
        end
        valid = 1'b0;
        consume();
    endtask

    task automatic test_hdr_err();
        send_flit(12'h611);
        send_flit(12'h722);
        send_flit(12'h633);
        valid = 1'b0;
        n_checks++;
        if ({vo, herr, dout, dest, src} !== {1'b1, 1'b1, 20'h32211, 2'd1, 2'd2}) begin
            n_fail++;
            $display("FAIL hdr_err_set: got v=%b err=%b data=%h d=%0d s=%0d want 1 1 32211 1 2",
                     vo, herr, dout, dest, src);
        end
        consume();
        send_flit(12'h6AB);
        send_flit(12'h6CD);
        send_flit(12'h6EF);
        valid = 1'b0;
        n_checks++;
        if ({vo, herr, dout} !== {1'b1, 1'b0, 20'hFCDAB}) begin
            n_fail++;
            $display("FAIL hdr_err_clear: got v=%b err=%b data=%h want 1 0 fcdab", vo, herr, dout);
        end
        consume();
    endtask

    task automatic test_async_reset();
        send_flit(12'h6AB);
        send_flit(12'h6CD);
        valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ready, vo, herr, dout} !== {1'b1, 1'b0, 1'b0, 20'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got rdy=%b v=%b err=%b data=%h want 1 0 0 00000", ready, vo, herr, dout);
        end
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        send_flit(12'h512);
        send_flit(12'h534);
        send_flit(12'h556);
        valid = 1'b0;
        n_checks++;
        if ({vo, herr, dout, dest, src} !== {1'b1, 1'b0, 20'h63412, 2'd1, 2'd1}) begin
            n_fail++;
            $display("FAIL after_reset_msg: got v=%b err=%b data=%h d=%0d s=%0d want 1 0 63412 1 1",
                     vo, herr, dout, dest, src);
        end
        consume();
    endtask

    task automatic test_single();
        for (int i = 0; i < 4; i++) begin
            logic [1:0]  d;
            logic [1:0]  s;
            logic [19:0] p;
            d = 2'($urandom_range(0, 3));
            s = 2'($urandom_range(0, 3));
            p = 20'($urandom);
            valid1 = 1'b1;
            data1  = {d, s, p};
            @(posedge clk); #1;
            valid1 = 1'b0;
            n_checks++;
            if ({vo1, ready1, dout1, dest1, src1, herr1} !== {1'b1, 1'b0, p, d, s, 1'b0}) begin
                n_fail++;
                $display("FAIL single_msg[%0d]: got v=%b rdy=%b data=%h d=%0d s=%0d want 1 0 %h %0d %0d",
                         i, vo1, ready1, dout1, dest1, src1, p, d, s);
            end
            yumi1 = 1'b1;
            @(posedge clk); #1;
            yumi1 = 1'b0;
            n_checks++;
            if ({vo1, ready1} !== 2'b01) begin
                n_fail++;
                $display("FAIL single_release[%0d]: got v,rdy=%b want 01", i, {vo1, ready1});
            end
        end
    endtask

    task automatic test_random();
        int got = 0;
        exp_q.delete();
        fork
            begin : driver
                for (int m = 0; m < 1000 && abort == 0; m++) begin
                    logic [19:0] msg;
                    logic [1:0]  d;
                    logic [1:0]  s;
                    logic [23:0] full;
                    msg  = 20'($urandom);
                    d    = 2'($urandom_range(0, 3));
                    s    = 2'($urandom_range(0, 3));
                    full = {4'($urandom), msg};
                    exp_q.push_back({msg, d, s});
                    for (int k = 0; k < 3 && abort == 0; k++) begin
                        valid = 1'b0;
                        while ($urandom_range(0, 1) == 0) begin
                            @(posedge clk); #1;
                        end
                        send_flit({d, s, full[k*8 +: 8]});
                    end
                end
                valid = 1'b0;
            end
            begin : consumer
                while (got < 1000 && abort == 0) begin
                    int          n;
                    logic [23:0] want;
                    logic [23:0] seen;
                    n = 0;
                    while (!vo && n < 300) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    if (!vo) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rand_timeout: got valid_o=0 want message %0d within 300 cycles", got);
                        abort = 1;
                        break;
                    end
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL rand_dup: got extra message data=%h want none", dout);
                        want = 'x;
                    end else begin
                        want = exp_q.pop_front();
                        if ({dout, dest, src, herr, ready} !== {want, 1'b0, 1'b0}) begin
                            n_fail++;
                            $display("FAIL rand_msg[%0d]: got data=%h d=%0d s=%0d err=%b rdy=%b want %h %0d %0d 0 0",
                                     got, dout, dest, src, herr, ready, want[23:4], want[3:2], want[1:0]);
                        end
                    end
                    seen = {dout, dest, src};
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk); #1;
                        n_checks++;
                        if ({vo, dout, dest, src} !== {1'b1, seen}) begin
                            n_fail++;
                            $display("FAIL rand_hold[%0d]: got v=%b data=%h want 1 %h", got, vo, dout, seen[23:4]);
                        end
                    end
                    consume();
                    got++;
                end
            end
        join
        n_checks++;
        if (got != 1000 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count: got %0d received, %0d pending want 1000 received, 0 pending",
                     got, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_hdr_err();
        test_async_reset();
        test_single();
        if (abort == 0) test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
